mesh_port_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer for one mesh output terminal. NUM_REQ input FIFOs
//  (first-word-fallthrough, pndng/pop style) compete for a single downstream FIFO.

---
 rtl/mesh_port_arbiter.sv | 111 +++++++++++
 tb/tb_mesh_port_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_port_arbiter.sv
// mesh_port_arbiter: round-robin sequencer for one mesh output terminal.
// NUM_REQ first-word-fallthrough input FIFOs compete for one downstream FIFO.
// Each round picks a winner, pops exactly one word into hold_reg, and pushes it
// downstream once out_full is low (IDLE -> LOAD -> SEND -> IDLE).
// Optional build macro MESH_ARB_STATS_EN adds saturating per-requester grant
// counters (grant_cnt) with a synchronous clear (stats_clr).
module mesh_port_arbiter #(
    parameter int PCKG_SZ = 40,
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_pndng,
    input  logic [NUM_REQ*PCKG_SZ-1:0]   req_data,
    output logic [NUM_REQ-1:0]           req_pop,
    output logic [PCKG_SZ-1:0]           out_data,
    output logic                         out_push,
    input  logic                         out_full,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
`ifdef MESH_ARB_STATS_EN
    output logic [NUM_REQ*CNT_W-1:0]     grant_cnt,
    input  logic                         stats_clr,
`endif
    output logic                         busy
);

    localparam int IDW = $clog2(NUM_REQ);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] SEND = 2'd2;

    logic [1:0]         state;
    logic [IDW-1:0]     last_ptr;
    logic [IDW-1:0]     winner;
    logic [PCKG_SZ-1:0] hold_reg;

    // Round-robin search: first pending requester at or after last_ptr+1, with wrap.
    // Iterating from the farthest offset down lets the nearest match win.
    always_comb begin
        int       pos;
        logic [IDW-1:0] idx;
        winner = last_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = (int'(last_ptr) + 1 + k) % NUM_REQ;
            idx = IDW'(pos);
            if (req_pndng[idx]) winner = idx;
        end
    end

    // Main sequencer; a packet held at reset time is dropped (it was already popped).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            grant_id <= '0;
            last_ptr <= IDW'(NUM_REQ - 1);
            hold_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_pndng) begin
                        grant_id <= winner;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    // pndng is not rechecked: a requester never withdraws without a pop
                    hold_reg <= req_data[int'(grant_id)*PCKG_SZ +: PCKG_SZ];
                    state    <= SEND;
                end
                SEND: begin
                    if (!out_full) begin
                        last_ptr <= grant_id;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // One-hot pop strobe, only during the single LOAD cycle.
    always_comb begin
        req_pop = '0;
        if (state == LOAD) req_pop[grant_id] = 1'b1;
    end

    // Push as soon as there is room; out_data is only meaningful with out_push.
    assign out_push = (state == SEND) && !out_full;
    assign out_data = hold_reg;
    assign busy     = (state != IDLE);

`ifdef MESH_ARB_STATS_EN
    logic [NUM_REQ-1:0][CNT_W-1:0] cnt;

    assign grant_cnt = cnt;

    // Grant counters bump on LOAD and saturate; a clear beats a coincident grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (stats_clr) begin
            cnt <= '0;
        end else if (state == LOAD && cnt[grant_id] != '1) begin
            cnt[grant_id] <= cnt[grant_id] + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mesh_port_arbiter.sv
// Testbench for mesh_port_arbiter: FIFO queues modelled in the bench, expected
// grant order built by a round-robin walk over queue contents.
module tb_mesh_port_arbiter;

    localparam int PW = 40;
    localparam int NR = 4;
`ifdef MESH_ARB_STATS_EN
    localparam int CW = 2;
`else
    localparam int CW = 16;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     req_pndng = '0;
    logic [NR*PW-1:0]  req_data = '0;
    logic [NR-1:0]     req_pop;
    logic [PW-1:0]     out_data;
    logic              out_push;
    logic              out_full = 1'b0;
    logic [1:0]        grant_id;
    logic              busy;
`ifdef MESH_ARB_STATS_EN
    logic [NR*CW-1:0]  grant_cnt;
    logic              stats_clr = 1'b0;
`endif

    always #5 clk = ~clk;

    mesh_port_arbiter #(.PCKG_SZ(PW), .NUM_REQ(NR), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_pndng (req_pndng),
        .req_data  (req_data),
        .req_pop   (req_pop),
        .out_data  (out_data),
        .out_push  (out_push),
        .out_full  (out_full),
        .grant_id  (grant_id),
`ifdef MESH_ARB_STATS_EN
        .grant_cnt (grant_cnt),
        .stats_clr (stats_clr),
`endif
        .busy      (busy)
    );

    logic [PW-1:0] q[NR][$];
    int            exp_id[$];
    logic [PW-1:0] exp_data[$];
    int            n_assert = 0;
    int            n_fail = 0;
    int            cycle = 0;
    logic [NR-1:0] s_pop = '0;
    logic          s_push;
    logic [PW-1:0] s_data;
    logic [1:0]    s_gid;
    logic          s_busy;
    logic          full_v = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_pndng[i]        = (q[i].size() != 0);
            req_data[i*PW +: PW] = (q[i].size() != 0) ? q[i][0] : '0;
        end
        out_full = full_v;
    endtask

    // One clock: apply last sampled pop to the queues, drive, sample at negedge.
    task automatic cyc();
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++)
            if (s_pop[i] && q[i].size() != 0) void'(q[i].pop_front());
        s_pop = '0;
        drive();
        @(negedge clk);
        s_pop  = req_pop;
        s_push = out_push;
        s_data = out_data;
        s_gid  = grant_id;
        s_busy = busy;
        cycle++;
    endtask

    task automatic do_reset();
        for (int i = 0; i < NR; i++) q[i].delete();
        full_v = 1'b0;
        reset  = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
    endtask

    // Reference: round-robin over queue contents, starting after requester NR-1.
    task automatic build_expect();
        int cnt[NR];
        int pos[NR];
        int ptr;
        int left;
        ptr  = NR - 1;
        left = 0;
        exp_id.delete();
        exp_data.delete();
        for (int i = 0; i < NR; i++) begin
            cnt[i] = q[i].size();
            pos[i] = 0;
            left  += cnt[i];
        end
        while (left > 0) begin
            for (int k = 1; k <= NR; k++) begin
                int j;
                j = (ptr + k) % NR;
                if (cnt[j] > pos[j]) begin
                    exp_id.push_back(j);
                    exp_data.push_back(q[j][pos[j]]);
                    pos[j]++;
                    ptr = j;
                    left--;
                    break;
                end
            end
        end
    endtask

    task automatic run(input int maxc, input bit rnd, input bit spacing);
        int gi;
        int pi;
        int last;
        gi = 0; pi = 0; last = 0;
        for (int c = 0; c < maxc && pi < exp_data.size(); c++) begin
            if (rnd) full_v = ($urandom_range(0, 3) == 0);
            cyc();
            chk("pop_push_excl", 64'((s_pop != 0) && s_push), 0);
            if (s_pop != 0) begin
                chk("pop_onehot", 64'($onehot(s_pop)), 1);
                if (gi < exp_id.size()) begin
                    chk("grant_id", 64'(s_gid), 64'(exp_id[gi]));
                    chk("pop_vec", 64'(s_pop), 64'(1 << exp_id[gi]));
                end
                gi++;
            end
            if (s_push) begin
                if (pi < exp_data.size()) chk("push_data", 64'(s_data), 64'(exp_data[pi]));
                if (spacing && pi > 0) chk("push_spacing", 64'(cycle - last), 3);
                last = cycle;
                pi++;
            end
        end
        full_v = 1'b0;
        chk("drained", 64'(pi), 64'(exp_data.size()));
    endtask

    initial begin
        logic [PW-1:0] v;
        int            guard;

        // Reset held with all requesters pending
        #1 reset = 1'b0;
        for (int i = 0; i < NR; i++) q[i].push_back(PW'(i + 1));
        cyc(); cyc(); cyc();
        chk("rst_pop", 64'(s_pop), 0);
        chk("rst_push", 64'(s_push), 0);
        chk("rst_gid", 64'(s_gid), 0);
        chk("rst_busy", 64'(s_busy), 0);
        chk("rst_data", 64'(s_data), 0);
        do_reset();

        // Single requester 2
        q[2].push_back(40'h05_0000_0ABC);
        cyc();
        chk("s2_idle_busy", 64'(s_busy), 0);
        chk("s2_idle_pop", 64'(s_pop), 0);
        cyc();
        chk("s2_pop", 64'(s_pop), 64'(4'b0100));
        chk("s2_gid", 64'(s_gid), 2);
        chk("s2_busy_load", 64'(s_busy), 1);
        cyc();
        chk("s2_push", 64'(s_push), 1);
        chk("s2_data", 64'(s_data), 64'(40'h05_0000_0ABC));
        chk("s2_pop_send", 64'(s_pop), 0);
        chk("s2_busy_send", 64'(s_busy), 1);
        cyc();
        chk("s2_busy_after", 64'(s_busy), 0);
        chk("s2_push_after", 64'(s_push), 0);

        // All pending: 0,1,2,3,0,1,... one push per 3 cycles
        do_reset();
        for (int i = 0; i < NR; i++)
            for (int n = 0; n < 3; n++) q[i].push_back(PW'(16 * i + n + 40'h77_0000_0000));
        build_expect();
        run(200, 1'b0, 1'b1);

        // Backpressure for 10 cycles in SEND
        do_reset();
        full_v = 1'b1;
        v = 40'h12_3456_789A;
        q[0].push_back(v);
        cyc();
        cyc();
        chk("bp_pop", 64'(s_pop), 1);
        for (int n = 0; n < 10; n++) begin
            cyc();
            chk("bp_push", 64'(s_push), 0);
            chk("bp_pop_stall", 64'(s_pop), 0);
            chk("bp_data", 64'(s_data), 64'(v));
        end
        full_v = 1'b0;
        cyc();
        chk("bp_release_push", 64'(s_push), 1);
        chk("bp_release_data", 64'(s_data), 64'(v));
        cyc();

        // Reset asserted during SEND
        do_reset();
        full_v = 1'b1;
        q[3].push_back(40'hAB_CDEF_0123);
        cyc(); cyc(); cyc();
        chk("mr_busy_send", 64'(s_busy), 1);
        reset = 1'b0;
        #1;
        chk("mr_pop", 64'(req_pop), 0);
        chk("mr_push", 64'(out_push), 0);
        chk("mr_gid", 64'(grant_id), 0);
        chk("mr_busy", 64'(busy), 0);
        chk("mr_data", 64'(out_data), 0);
        full_v = 1'b0;
        for (int i = 0; i < NR; i++) q[i].push_back(PW'(i + 100));
        cyc();
        reset = 1'b1;
        guard = 0;
        do begin
            cyc();
            guard++;
        end while (s_pop == 0 && guard < 10);
        chk("mr_first_gid", 64'(s_gid), 0);
        chk("mr_first_pop", 64'(s_pop), 1);

        // Randomized traffic with random backpressure
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int i = 0; i < NR; i++) begin
                int n;
                n = $urandom_range(0, 6);
                for (int k = 0; k < n; k++) q[i].push_back({$urandom(), $urandom()});
            end
            build_expect();
            run(3000, 1'b1, 1'b0);
        end

`ifdef MESH_ARB_STATS_EN
        // Saturation and clear
        do_reset();
        for (int n = 0; n < 5; n++) q[1].push_back(PW'(n + 9));
        build_expect();
        run(200, 1'b0, 1'b0);
        cyc();
        chk("cnt1_sat", 64'(grant_cnt[1*CW +: CW]), 3);
        chk("cnt0", 64'(grant_cnt[0 +: CW]), 0);
        q[0].push_back(40'h1);
        cyc();
        cyc();
        chk("clr_pop", 64'(s_pop), 1);
        stats_clr = 1'b1;
        cyc();
        stats_clr = 1'b0;
        chk("cnt_clr", 64'(grant_cnt), 0);
        cyc();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
